// File: rtl/cpu_instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, the default
// reset PC, FSM state encodings and the prefetch buffer entry layout.
package cpu_instr_fetch_pkg;

  localparam int CPU_XLEN         = 32;
  localparam int CPU_INSTR_LENGTH = 32;
  localparam int CPU_BUS_AW       = 26;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_CLEAR = '{instr: 32'd0, pc: 32'd0, misaligned: 1'b0};

  // Instructions are word aligned; only the two low address bits matter.
  function automatic logic pc_is_aligned(input logic [1:0] pc_lo);
    return (pc_lo == 2'b00);
  endfunction

endpackage

// File: rtl/cpu_instr_fetch_fifo.sv
// Two-entry prefetch buffer. Entries shift toward slot 0 so the head is
// always a register and stays stable until it is popped.
module cpu_fetch_fifo
  import cpu_instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        push_misaligned,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count,
  output logic [31:0] head_instr,
  output logic [31:0] head_pc,
  output logic        head_misaligned
);

  fetch_entry_t mem_r [2];
  logic [1:0]   count_r;
  logic         push_s;
  logic         pop_s;
  fetch_entry_t push_entry_s;

  // Qualify requests so an empty pop or a full push can never corrupt state.
  always_comb begin
    pop_s                   = pop && (count_r != 2'd0);
    push_s                  = push && ((count_r != 2'd2) || pop_s);
    push_entry_s.instr      = push_instr;
    push_entry_s.pc         = push_pc;
    push_entry_s.misaligned = push_misaligned;
  end

  // Buffer storage and occupancy; flush empties it in one cycle.
  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      mem_r[0] <= ENTRY_CLEAR;
      mem_r[1] <= ENTRY_CLEAR;
      count_r  <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            mem_r[0] <= push_entry_s;
          end else begin
            mem_r[1] <= push_entry_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          mem_r[0] <= mem_r[1];
          count_r  <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            mem_r[0] <= push_entry_s;
          end else begin
            mem_r[0] <= mem_r[1];
            mem_r[1] <= push_entry_s;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign full            = (count_r == 2'd2);
  assign empty           = (count_r == 2'd0);
  assign count           = count_r;
  assign head_instr      = mem_r[0].instr;
  assign head_pc         = mem_r[0].pc;
  assign head_misaligned = mem_r[0].misaligned;

endmodule

// File: rtl/cpu_instr_fetch.sv
// Instruction fetch unit: issues word reads to the bus, queues returned
// words in a 2-entry prefetch buffer, and handles redirects and
// misaligned-target faults.
module cpu_instr_fetch
  import cpu_instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        bus_req,
  output logic [25:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_misaligned,
  input  logic        instr_ready
);

  localparam logic [1:0] DEPTH_C = FIFO_DEPTH[1:0];

  fetch_state_e                  state_r;
  fetch_state_e                  state_nxt_s;
  logic [CPU_XLEN-1:0]           fetch_pc_r;
  logic [CPU_XLEN-1:0]           fetch_pc_nxt_s;
  logic [CPU_BUS_AW-1:0]         bus_addr_r;
  logic [CPU_BUS_AW-1:0]         bus_addr_nxt_s;
  logic                          bus_req_r;
  logic                          push_s;
  logic [CPU_INSTR_LENGTH-1:0]   push_instr_s;
  logic                          push_misaligned_s;
  logic                          pop_s;
  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic [1:0]                    fifo_count_s;
  logic                          slot_free_s;

  // A request is only started when no entry could overflow the buffer;
  // in IDLE nothing is outstanding, so buffer occupancy alone decides.
  assign slot_free_s = !fifo_full_s && (fifo_count_s < DEPTH_C);
  assign pop_s       = instr_valid && instr_ready;

  // Next-state, next fetch PC and buffer push decisions.
  always_comb begin
    state_nxt_s       = state_r;
    fetch_pc_nxt_s    = fetch_pc_r;
    bus_addr_nxt_s    = bus_addr_r;
    push_s            = 1'b0;
    push_instr_s      = 32'd0;
    push_misaligned_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_nxt_s = redirect_pc;
        end else if (slot_free_s) begin
          if (pc_is_aligned(fetch_pc_r[1:0])) begin
            state_nxt_s    = ST_WAIT;
            bus_addr_nxt_s = fetch_pc_r[25:0];
          end else begin
            push_s            = 1'b1;
            push_misaligned_s = 1'b1;
            state_nxt_s       = ST_HALT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt_s = redirect_pc;
          state_nxt_s    = bus_ack ? ST_IDLE : ST_FLUSH;
        end else if (bus_ack) begin
          push_s         = 1'b1;
          push_instr_s   = bus_rdata;
          fetch_pc_nxt_s = fetch_pc_r + 32'd4;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        // The old request stays on the bus until it is acknowledged; its
        // data is dropped. A completing ack always ends the flush.
        if (redirect_valid) begin
          fetch_pc_nxt_s = redirect_pc;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        if (bus_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          fetch_pc_nxt_s = redirect_pc;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, fetch PC and registered bus request/address.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      bus_addr_r <= RESET_PC[25:0];
      bus_req_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      bus_addr_r <= bus_addr_nxt_s;
      bus_req_r  <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_FLUSH);
    end
  end

  cpu_fetch_fifo u_fifo (
    .clk             (clk),
    .clr_n           (clr_n),
    .push            (push_s),
    .pop             (pop_s),
    .flush           (redirect_valid),
    .push_instr      (push_instr_s),
    .push_pc         (fetch_pc_r),
    .push_misaligned (push_misaligned_s),
    .full            (fifo_full_s),
    .empty           (fifo_empty_s),
    .count           (fifo_count_s),
    .head_instr      (instr),
    .head_pc         (instr_pc),
    .head_misaligned (instr_misaligned)
  );

  assign bus_req     = bus_req_r;
  assign bus_addr    = bus_addr_r;
  assign instr_valid = !fifo_empty_s;

endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Bench for cpu_instr_fetch: directed scenarios plus a randomized run, all
// cross-checked cycle by cycle against a queue-based reference model.
module tb_cpu_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bus_req;
  logic [25:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_misaligned;
  logic        instr_ready;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_out, m_stale, m_halt;
  bit          hold_pend;
  logic [31:0] hold_instr, hold_pc;
  logic        hold_mis;

  always #5 clk = ~clk;

  cpu_instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .clr_n            (clr_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .bus_req          (bus_req),
    .bus_addr         (bus_addr),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_misaligned (instr_misaligned),
    .instr_ready      (instr_ready)
  );

  // Reference model: evaluates the upcoming rising edge from the current
  // (stable) outputs and the inputs just driven.
  task automatic model_edge();
    ent_t e;
    if (!clr_n) begin
      m_q.delete();
      m_pc = RESET_PC; m_out = 0; m_stale = 0; m_halt = 0; hold_pend = 0;
      return;
    end
    checks++;
    if ((instr_valid === 1'b1 && m_q.size() == 0) ||
        (instr_valid !== 1'b1 && m_q.size() != 0 && !m_q[0].mis)) begin
      failures++;
      $display("FAIL model_valid: instr_valid=%b model_entries=%0d", instr_valid, m_q.size());
    end
    if (hold_pend) begin
      checks++;
      if (instr !== hold_instr || instr_pc !== hold_pc || instr_misaligned !== hold_mis) begin
        failures++;
        $display("FAIL hold_stable: got %h/%h/%b want %h/%h/%b", instr, instr_pc, instr_misaligned,
                 hold_instr, hold_pc, hold_mis);
      end
    end
    hold_pend  = (instr_valid === 1'b1) && !instr_ready && !redirect_valid;
    hold_instr = instr; hold_pc = instr_pc; hold_mis = instr_misaligned;
    if (m_out) begin
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== m_req_addr[25:0]) begin
        failures++;
        $display("FAIL req_hold: bus_req=%b addr=%h want req=1 addr=%h", bus_req, bus_addr, m_req_addr[25:0]);
      end
    end else if (bus_req === 1'b1) begin
      checks++;
      if (m_halt || bus_addr !== m_pc[25:0] || m_q.size() >= 2) begin
        failures++;
        $display("FAIL req_start: addr=%h want %h halted=%0d entries=%0d", bus_addr, m_pc[25:0], m_halt, m_q.size());
      end
      m_out = 1; m_stale = 0; m_req_addr = m_pc;
    end
    if (redirect_valid) begin
      m_q.delete();
      if (m_out) begin
        if (bus_ack) m_out = 0;
        else m_stale = 1;
      end
      m_pc   = redirect_pc;
      m_halt = (redirect_pc[1:0] != 2'b00);
      if (m_halt) begin
        e.instr = 32'd0; e.pc = redirect_pc; e.mis = 1'b1;
        m_q.push_back(e);
      end
    end else begin
      if (instr_valid === 1'b1 && instr_ready) begin
        checks++;
        if (m_q.size() == 0) begin
          failures++;
          $display("FAIL pop_entry: popped pc=%h but model buffer empty", instr_pc);
        end else begin
          e = m_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc || instr_misaligned !== e.mis) begin
            failures++;
            $display("FAIL pop_entry: got %h/%h/%b want %h/%h/%b", instr, instr_pc, instr_misaligned,
                     e.instr, e.pc, e.mis);
          end
        end
      end
      if (bus_ack && m_out) begin
        m_out = 0;
        if (!m_stale) begin
          e.instr = bus_rdata; e.pc = m_req_addr; e.mis = 1'b0;
          m_q.push_back(e);
          m_pc = m_req_addr + 32'd4;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0; redirect_valid = 1'b0; bus_ack = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 ||
        instr_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: req=%b valid=%b instr=%h pc=%h mis=%b want all 0",
               bus_req, instr_valid, instr, instr_pc, instr_misaligned);
    end
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== RESET_PC[25:0]) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h want 1/%h", bus_req, bus_addr, RESET_PC[25:0]);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    bit ok;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      checks++;
      if (!ok || bus_addr !== 26'(k * 4) || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_addr: ok=%0d addr=%h valid=%b want addr=%h valid=0", ok, bus_addr, instr_valid, k * 4);
      end
      d = $urandom;
      bus_ack = 1'b1; bus_rdata = d;
      tick();
      bus_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr !== d) begin
        failures++;
        $display("FAIL seq_entry: valid=%b pc=%h instr=%h want 1/%h/%h", instr_valid, instr_pc, instr, k * 4, d);
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_req;
    logic [25:0] a;
    do_reset();
    instr_ready = 1'b0; n_req = 0; a = 26'd0;
    for (int t = 0; t < 12; t++) begin
      bus_ack = bus_req; bus_rdata = $urandom;
      if (bus_req === 1'b1) n_req++;
      tick();
    end
    bus_ack = 1'b0;
    checks++;
    if (n_req != 2 || bus_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL bp_fill: requests=%0d req=%b valid=%b pc=%h want 2/0/1/0", n_req, bus_req, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
      failures++;
      $display("FAIL bp_pop: valid=%b pc=%h want 1/4", instr_valid, instr_pc);
    end
    n_req = 0;
    for (int t = 0; t < 8; t++) begin
      bus_ack = bus_req; bus_rdata = $urandom;
      if (bus_req === 1'b1) begin
        n_req++;
        a = bus_addr;
      end
      tick();
    end
    bus_ack = 1'b0;
    checks++;
    if (n_req != 1 || a !== 26'h8 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_refill: requests=%0d addr=%h req=%b want 1/8/0", n_req, a, bus_req);
    end
  endtask

  task automatic test_redirect_flush();
    int n;
    bit ok;
    logic [31:0] d;
    do_reset();
    instr_ready = 1'b1; n = 0;
    for (int t = 0; t < 20 && n < 2; t++) begin
      bus_ack = bus_req; bus_rdata = $urandom;
      if (bus_req === 1'b1) n++;
      tick();
    end
    bus_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || bus_addr !== 26'h8) begin
      failures++;
      $display("FAIL rf_wait8: ok=%0d addr=%h want 8", ok, bus_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== 26'h8 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL rf_hold: req=%b addr=%h valid=%b want 1/8/0", bus_req, bus_addr, instr_valid);
      end
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_discard: valid=%b pc=%h want valid=0", instr_valid, instr_pc);
    end
    wait_req(ok);
    checks++;
    if (!ok || bus_addr !== 26'h100) begin
      failures++;
      $display("FAIL rf_newaddr: ok=%0d addr=%h want 100", ok, bus_addr);
    end
    d = $urandom;
    bus_ack = 1'b1; bus_rdata = d; instr_ready = 1'b0;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== d) begin
      failures++;
      $display("FAIL rf_entry: valid=%b pc=%h instr=%h want 1/100/%h", instr_valid, instr_pc, instr, d);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    logic [31:0] d;
    do_reset();
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h102 || instr_misaligned !== 1'b1 ||
        instr !== 32'd0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL mis_entry: valid=%b pc=%h mis=%b instr=%h req=%b want 1/102/1/0/0",
               instr_valid, instr_pc, instr_misaligned, instr, bus_req);
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (bus_req !== 1'b0) begin
        failures++;
        $display("FAIL mis_halt_full: req=%b want 0", bus_req);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (bus_req !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL mis_halt_empty: req=%b valid=%b want 0/0", bus_req, instr_valid);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || bus_addr !== 26'h200) begin
      failures++;
      $display("FAIL mis_resume: ok=%0d addr=%h want 200", ok, bus_addr);
    end
    d = $urandom;
    bus_ack = 1'b1; bus_rdata = d;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_misaligned !== 1'b0 || instr !== d) begin
      failures++;
      $display("FAIL mis_resume_entry: valid=%b pc=%h mis=%b instr=%h want 1/200/0/%h",
               instr_valid, instr_pc, instr_misaligned, instr, d);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_reset();
    instr_ready = 1'b0;
    wait_req(ok);
    bus_ack = 1'b1; bus_rdata = $urandom;
    tick();
    bus_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || bus_addr !== 26'h4 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL sc_setup: ok=%0d addr=%h valid=%b want 4/1", ok, bus_addr, instr_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
    bus_ack = 1'b1; bus_rdata = $urandom;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b0; bus_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL sc_empty: valid=%b req=%b want 0/0", instr_valid, bus_req);
    end
    wait_req(ok);
    checks++;
    if (!ok || bus_addr !== 26'h40) begin
      failures++;
      $display("FAIL sc_newaddr: ok=%0d addr=%h want 40", ok, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = $urandom;
    tick();
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    do_reset();
    instr_ready = 1'b0;
    wait_req(ok);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL rw_setup: ok=%0d valid=%b want 1", ok, instr_valid);
    end
    clr_n = 1'b0;
    tick();
    checks++;
    if (bus_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 ||
        instr_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL rw_reset_values: req=%b valid=%b instr=%h pc=%h mis=%b want all 0",
               bus_req, instr_valid, instr, instr_pc, instr_misaligned);
    end
    clr_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hBAD0_0BAD;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || bus_req !== 1'b1 || bus_addr !== RESET_PC[25:0]) begin
      failures++;
      $display("FAIL rw_stray_ack: valid=%b req=%b addr=%h want 0/1/%h", instr_valid, bus_req, bus_addr, RESET_PC[25:0]);
    end
    bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== 32'h1357_9BDF) begin
      failures++;
      $display("FAIL rw_first_entry: valid=%b pc=%h instr=%h want 1/%h/13579bdf", instr_valid, instr_pc, instr, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      bus_ack        = (bus_req === 1'b1) && ($urandom_range(0, 2) == 0);
      bus_rdata      = $urandom;
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
    end
    bus_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0; instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_misaligned();
    test_same_cycle();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
